// File: rtl/cell_outline_render.sv
// Draws (or erases) the square outline of one grid cell as a stream of pixel writes.
// Only ring pixels are visited; interior columns are skipped in a single step.
module cell_outline_render #(
  parameter int unsigned CELL     = 28,
  parameter int unsigned THICK    = 1,
  parameter int unsigned ORIGIN_X = 8,
  parameter int unsigned ORIGIN_Y = 8,
  parameter int unsigned GRID_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              erase,
  input  logic              hilite,
  input  logic [GRID_W-1:0] cell_x,
  input  logic [GRID_W-1:0] cell_y,
  input  logic              pix_ready,
  output logic [8:0]        x,
  output logic [7:0]        y,
  output logic              colour,
  output logic              write_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CW = $clog2(CELL);
  localparam logic [CW-1:0] LAST    = CW'(CELL - 1);
  localparam logic [CW-1:0] THK     = CW'(THICK);
  localparam logic [CW-1:0] LEFT_HI = CW'(THICK - 1);     // last column of the left band
  localparam logic [CW-1:0] RIGHT_LO = CW'(CELL - THICK); // first column of the right band
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   px_q, px_d, py_q, py_d;
  logic [8:0]      base_x_q, base_x_d;
  logic [7:0]      base_y_q, base_y_d;
  logic [8:0]      x_d;
  logic [7:0]      y_d;
  logic            colour_d, write_en_d;
  logic [GRID_W:0] idx_sum;
  logic            bg, accept, last_px, interior_row;

  assign idx_sum      = {1'b0, cell_x} + {1'b0, cell_y};
  assign bg           = ~idx_sum[0];
  assign accept       = write_en & pix_ready;
  assign last_px      = (px_q == LAST) && (py_q == LAST);
  assign interior_row = (py_q >= THK) && (py_q < RIGHT_LO);

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    px_d       = px_q;
    py_d       = py_q;
    base_x_d   = base_x_q;
    base_y_d   = base_y_q;
    x_d        = x;
    y_d        = y;
    colour_d   = colour;
    write_en_d = write_en;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StScan;
          px_d       = '0;
          py_d       = '0;
          base_x_d   = 9'(ORIGIN_X + CELL * 32'(cell_x));
          base_y_d   = 8'(ORIGIN_Y + CELL * 32'(cell_y));
          x_d        = base_x_d;
          y_d        = base_y_d;
          // Colour is fixed for the whole operation, so it is resolved once here.
          colour_d   = (!erase && hilite) ? ~bg : bg;
          write_en_d = 1'b1;
        end
      end
      StScan: begin
        if (accept) begin
          if (last_px) begin
            state_d    = StDone;
            write_en_d = 1'b0;
          end else begin
            if (px_q == LAST) begin
              px_d = '0;
              py_d = py_q + ONE;
            end else if (interior_row && (px_q == LEFT_HI)) begin
              px_d = RIGHT_LO;
            end else begin
              px_d = px_q + ONE;
            end
            x_d = base_x_q + 9'(px_d);
            y_d = base_y_q + 8'(py_d);
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      px_q     <= '0;
      py_q     <= '0;
      base_x_q <= '0;
      base_y_q <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= 1'b0;
      write_en <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_q     <= px_d;
      py_q     <= py_d;
      base_x_q <= base_x_d;
      base_y_q <= base_y_d;
      x        <= x_d;
      y        <= y_d;
      colour   <= colour_d;
      write_en <= write_en_d;
    end
  end

endmodule

// File: tb/tb_cell_outline_render.sv
// Bench for cell_outline_render: default instance plus a CELL=16/THICK=3 instance,
// each checked every cycle against a pixel-list model built from the ring definition.
module tb_cell_outline_render;

  localparam int CA = 28;
  localparam int TA = 1;
  localparam int CB = 16;
  localparam int TB = 3;
  localparam int OX = 8;
  localparam int OY = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       start_a = 1'b0, erase_a = 1'b0, hilite_a = 1'b0, rdy_a = 1'b0;
  logic [2:0] cx_a = '0, cy_a = '0;
  logic [8:0] xa;
  logic [7:0] ya;
  logic       ca, wea, busya, donea;

  logic       start_b = 1'b0, erase_b = 1'b0, hilite_b = 1'b0, rdy_b = 1'b0;
  logic [2:0] cx_b = '0, cy_b = '0;
  logic [8:0] xb;
  logic [7:0] yb;
  logic       cb, web, busyb, doneb;

  always #5 clk = ~clk;

  cell_outline_render dut_a (
    .clk(clk), .reset(reset), .start(start_a), .erase(erase_a), .hilite(hilite_a),
    .cell_x(cx_a), .cell_y(cy_a), .pix_ready(rdy_a),
    .x(xa), .y(ya), .colour(ca), .write_en(wea), .busy(busya), .done(donea)
  );

  cell_outline_render #(.CELL(16), .THICK(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .erase(erase_b), .hilite(hilite_b),
    .cell_x(cx_b), .cell_y(cy_b), .pix_ready(rdy_b),
    .x(xb), .y(yb), .colour(cb), .write_en(web), .busy(busyb), .done(doneb)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit in_ring(input int px, input int py, input int c, input int t);
    return (px < t) || (px >= c - t) || (py < t) || (py >= c - t);
  endfunction

  function automatic bit colour_of(input int cx, input int cy, input bit er, input bit hi);
    bit bg;
    bg = ((cx + cy) % 2) == 0;
    return (!er && hi) ? !bg : bg;
  endfunction

  logic [16:0] qa[$];
  logic [16:0] qb[$];
  int sta = 0, stb = 0, acca = 0, accb = 0;
  bit cola, colb;

  task automatic fill(input int which, input int cx, input int cy);
    int c;
    int t;
    logic [16:0] p;
    c = (which != 0) ? CB : CA;
    t = (which != 0) ? TB : TA;
    for (int py = 0; py < c; py++) begin
      for (int px = 0; px < c; px++) begin
        if (in_ring(px, py, c, t)) begin
          p = {9'(OX + cx * c + px), 8'(OY + cy * c + py)};
          if (which != 0) qb.push_back(p);
          else qa.push_back(p);
        end
      end
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      qa.delete();
      qb.delete();
      sta = 0;
      stb = 0;
    end else begin
      case (sta)
        0: if (start_a) begin
          fill(0, int'(cx_a), int'(cy_a));
          cola = colour_of(int'(cx_a), int'(cy_a), erase_a, hilite_a);
          acca = 0;
          sta = 1;
        end
        1: if (rdy_a) begin
          void'(qa.pop_front());
          acca++;
          if (qa.size() == 0) begin
            sta = 2;
            chk("count_a", acca, CA * CA - (CA - 2 * TA) * (CA - 2 * TA));
          end
        end
        default: sta = 0;
      endcase
      case (stb)
        0: if (start_b) begin
          fill(1, int'(cx_b), int'(cy_b));
          colb = colour_of(int'(cx_b), int'(cy_b), erase_b, hilite_b);
          accb = 0;
          stb = 1;
        end
        1: if (rdy_b) begin
          void'(qb.pop_front());
          accb++;
          if (qb.size() == 0) begin
            stb = 2;
            chk("count_b", accb, CB * CB - (CB - 2 * TB) * (CB - 2 * TB));
          end
        end
        default: stb = 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we_a", int'(wea), int'(sta == 1));
      chk("busy_a", int'(busya), int'(sta != 0));
      chk("done_a", int'(donea), int'(sta == 2));
      if (sta == 1) begin
        chk("x_a", int'(xa), int'(qa[0][16:8]));
        chk("y_a", int'(ya), int'(qa[0][7:0]));
        chk("colour_a", int'(ca), int'(cola));
      end
      chk("we_b", int'(web), int'(stb == 1));
      chk("busy_b", int'(busyb), int'(stb != 0));
      chk("done_b", int'(doneb), int'(stb == 2));
      if (stb == 1) begin
        chk("x_b", int'(xb), int'(qb[0][16:8]));
        chk("y_b", int'(yb), int'(qb[0][7:0]));
        chk("colour_b", int'(cb), int'(colb));
      end
    end
  end

  // ---------------- stimulus ----------------
  int fx, fy, fc, lx, ly, minx, maxx, miny, maxy, lat, acc;

  task automatic run_a(input int cx, input int cy, input bit er, input bit hi,
                       input int mode, input int abort_at);
    int cyc;
    @(negedge clk);
    cx_a = 3'(cx);
    cy_a = 3'(cy);
    erase_a = er;
    hilite_a = hi;
    start_a = 1'b1;
    rdy_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 1;
    acc = 0;
    lat = -1;
    fx = -1;
    fy = -1;
    fc = -1;
    minx = 9999;
    miny = 9999;
    maxx = -1;
    maxy = -1;
    while (cyc < 3000 && lat < 0) begin
      if (donea) begin
        lat = cyc;
      end else begin
        if (wea) begin
          if (fx < 0) begin
            fx = int'(xa);
            fy = int'(ya);
            fc = int'(ca);
          end
          lx = int'(xa);
          ly = int'(ya);
          if (lx < minx) minx = lx;
          if (lx > maxx) maxx = lx;
          if (ly < miny) miny = ly;
          if (ly > maxy) maxy = ly;
        end
        if (abort_at >= 0 && acc == abort_at) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk("abort_we", int'(wea), 0);
          chk("abort_busy", int'(busya), 0);
          chk("abort_done", int'(donea), 0);
          chk("abort_x", int'(xa), 0);
          return;
        end
        case (mode)
          0: rdy_a = 1'b1;
          1: rdy_a = ~rdy_a;
          default: rdy_a = 1'($urandom_range(0, 1));
        endcase
        if (wea && rdy_a) acc++;
        @(negedge clk);
        cyc++;
      end
    end
    chk("done_seen_a", int'(lat >= 0), 1);
  endtask

  task automatic run_b(input int cx, input int cy, input bit er, input bit hi);
    int cyc;
    int n;
    int lxp;
    int lyp;
    bit fin;
    @(negedge clk);
    cx_b = 3'(cx);
    cy_b = 3'(cy);
    erase_b = er;
    hilite_b = hi;
    start_b = 1'b1;
    rdy_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    n = 0;
    fin = 1'b0;
    while (cyc < 3000 && !fin) begin
      if (doneb) begin
        fin = 1'b1;
      end else begin
        if (web) begin
          lxp = int'(xb) - OX - cx * CB;
          lyp = int'(yb) - OY - cy * CB;
          chk("ring_b", int'(lxp >= 0 && lxp < CB && lyp >= 0 && lyp < CB &&
                             in_ring(lxp, lyp, CB, TB)), 1);
        end
        rdy_b = 1'($urandom_range(0, 1));
        // Restart requests while scanning must be ignored.
        start_b = (n < 100) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (web && rdy_b) n++;
        @(negedge clk);
        cyc++;
      end
    end
    start_b = 1'b0;
    chk("done_seen_b", int'(fin), 1);
    chk("pix_b", n, 156);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(xa), 0);
    chk("rst_y", int'(ya), 0);
    chk("rst_colour", int'(ca), 0);
    chk("rst_we", int'(wea), 0);
    chk("rst_busy", int'(busya), 0);
    chk("rst_done", int'(donea), 0);
    chk("rst_we_b", int'(web), 0);
    // Reset wins over a simultaneous start.
    start_a = 1'b1;
    @(negedge clk);
    chk("rst_prio_busy", int'(busya), 0);
    start_a = 1'b0;
    reset = 1'b0;
    chk_en = 1'b1;

    run_a(0, 0, 1'b0, 1'b1, 0, -1);
    chk("first_x", fx, 8);
    chk("first_y", fy, 8);
    chk("first_colour", fc, 0);
    chk("last_x", lx, 35);
    chk("last_y", ly, 35);
    chk("latency", lat, 109);
    chk("accepted", acc, 108);

    // Start during the done cycle is ignored.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    chk("start_in_done_busy", int'(busya), 0);
    @(negedge clk);
    chk("start_in_done_busy2", int'(busya), 0);

    run_a(7, 7, 1'b0, 1'b1, 0, -1);
    chk("c77_minx", minx, 204);
    chk("c77_maxx", maxx, 231);
    chk("c77_miny", miny, 204);
    chk("c77_maxy", maxy, 231);
    chk("c77_colour", fc, 0);

    run_a(1, 0, 1'b1, 1'b1, 0, -1);
    chk("erase_colour", fc, 0);
    run_a(1, 0, 1'b0, 1'b1, 0, -1);
    chk("draw_colour", fc, 1);

    run_a(2, 5, 1'b0, 1'b1, 1, -1);
    chk("toggle_accepted", acc, 108);

    run_a(3, 3, 1'b0, 1'b1, 0, 50);
    repeat (4) begin
      @(negedge clk);
      chk("post_abort_done", int'(donea), 0);
    end
    run_a(3, 3, 1'b0, 1'b1, 0, -1);
    chk("redraw_first_x", fx, 92);
    chk("redraw_first_y", fy, 92);

    repeat (8) begin
      run_a(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2, -1);
    end

    run_b(0, 0, 1'b0, 1'b1);
    run_b(5, 2, 1'b0, 1'b1);
    run_b(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cell_outline_render.md
CELL_OUTLINE_RENDER -- requirements
Module: cell_outline_render

Interface
REQ-001 SHALL have parameter CELL, default 28: cell pitch and outline size, in pixels (4..64).
REQ-002 SHALL have parameter THICK, default 1: outline thickness, in pixels (1..CELL/2-1).
REQ-003 SHALL have parameter ORIGIN_X, default 8: screen x of cell (0,0) top-left.
REQ-004 SHALL have parameter ORIGIN_Y, default 8: screen y of cell (0,0) top-left.
REQ-005 SHALL have parameter GRID_W, default 3: width of the cell index inputs.
REQ-006 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: request a draw; sampled only in IDLE.
REQ-009 SHALL have port erase, input, 1: mode latched with start; 1 = restore background, 0 = draw.
REQ-010 SHALL have port hilite, input, 1: latched with start; 0 forces background colour even in draw mode.
REQ-011 SHALL have ports cell_x and cell_y, input, GRID_W each: target cell index, latched with start.
REQ-012 SHALL have port pix_ready, input, 1: downstream accepts the pixel this cycle.
REQ-013 SHALL have port x, output, 9: pixel column.
REQ-014 SHALL have port y, output, 8: pixel row.
REQ-015 SHALL have port colour, output, 1: pixel colour.
REQ-016 SHALL have port write_en, output, 1: pixel on x/y/colour is valid.
REQ-017 SHALL have port busy, output, 1: high in SCAN and DONE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when the outline is complete.

Function
REQ-019 SHALL have states IDLE, SCAN and DONE; transitions: IDLE->SCAN on start, SCAN->DONE when the last pixel is accepted, DONE->IDLE unconditionally.
REQ-020 SHALL latch start, erase, hilite, cell_x and cell_y only in IDLE; start is ignored while busy.
REQ-021 SHALL scan local coordinates (px,py) row-major from (0,0) to (CELL-1,CELL-1).
REQ-022 SHALL emit only ring pixels: px<THICK, px>=CELL-THICK, py<THICK or py>=CELL-THICK.
REQ-023 SHALL skip interior pixels: on rows THICK..CELL-THICK-1, px jumps from THICK-1 directly to CELL-THICK.
REQ-024 SHALL emit exactly CELL^2-(CELL-2*THICK)^2 pixels per operation; 108 at the defaults.
REQ-025 SHALL hold write_en high every SCAN cycle and low in IDLE and DONE.
REQ-026 SHALL advance (px,py) only when write_en and pix_ready are both high; otherwise x, y and colour are held stable.
REQ-027 SHALL compute x = ORIGIN_X + cell_x*CELL + px and y = ORIGIN_Y + cell_y*CELL + py, using latched indices; results are truncated to port width.
REQ-028 SHALL register x, y, colour and write_en; the first pixel appears the cycle after start is sampled.
REQ-029 SHALL compute bg = ~(cell_x+cell_y)[0], with the sum GRID_W+1 bits wide.
REQ-030 SHALL drive colour = ~bg when draw mode and hilite=1, else bg.
REQ-031 SHALL assert done only in DONE, the cycle after the last pixel is accepted.
REQ-032 With pix_ready held high, SHALL make start-to-done latency equal to pixel count + 1 cycles.
REQ-033 SHALL allow start asserted in the same cycle as done to be ignored; a new start is accepted from the following IDLE cycle.

Reset
REQ-034 SHALL, on reset, enter IDLE and clear x, y, colour, write_en, busy, done and (px,py) to 0.
REQ-035 SHALL, on reset mid-SCAN, abort without a done pulse and emit no further pixels.
REQ-036 SHALL give reset priority over start in the same cycle.

Verification
REQ-037 SHALL cover this scenario: defaults, pix_ready=1, start with cell (0,0), erase=0, hilite=1 -> 108 write_en cycles; first pixel (8,8) colour 0; last pixel (35,35); done 109 cycles after start.
REQ-038 SHALL cover this scenario: cell (7,7) in draw mode -> pixels span x 204..231, y 204..231; colour 0.
REQ-039 SHALL cover this scenario: cell (1,0) with erase=1 -> colour 0 on every pixel; the same cell in draw mode with hilite=1 -> colour 1.
REQ-040 SHALL cover this scenario: pix_ready toggled every other cycle -> still exactly 108 unique pixels, no duplicates or skips, x/y/colour stable while stalled, done once.
REQ-041 SHALL cover this scenario: reset asserted at pixel 50 -> next cycle write_en=0, busy=0, no done pulse; a later start redraws from (0,0).
REQ-042 SHALL cover this scenario: THICK=3, CELL=16 -> 156 pixels; every pixel is in the ring and no interior pixel is emitted; start pulsed while busy has no effect.
